// File: rtl/app_seq_mult_unsigned6x6.sv
// rtl/app_seq_mult_unsigned6x6.sv - sequential radix-4 multiplier driving an external 2-bit partial-product layer
module app_seq_mult_unsigned6x6 #(
  parameter int width1 = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [width1-1:0]     A,
  input  logic [5:0]            B,
  output logic [width1-1:0]     lay_A,
  output logic                  lay_B_low,
  output logic                  lay_B_high,
  output logic                  lay_cin,
  input  logic [width1+1:0]     lay_sum,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [width1+5:0]     product,
  output logic                  ovf
);

  localparam int W = width1 + 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        k_q, k_d;
  logic [width1-1:0] a_q, a_d;
  logic [5:0]        b_q, b_d;
  logic [W-1:0]      acc_q, acc_d;
  logic              ovf_acc_q, ovf_acc_d;
  logic [W-1:0]      product_q, product_d;
  logic              ovf_q, ovf_d;
  logic              out_valid_q, out_valid_d;

  logic [2:0]        shift_amt;
  logic [W-1:0]      addend;
  logic [W:0]        sum_w;
  logic [5:0]        b_rest;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= 2'd0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      ovf_acc_q   <= 1'b0;
      product_q   <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      ovf_acc_q   <= ovf_acc_d;
      product_q   <= product_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Slice k weighs 4^k; the extra top bit of sum_w is the accumulator carry-out.
  always_comb begin
    shift_amt = {k_q, 1'b0};
    addend    = {4'b0000, lay_sum} << shift_amt;
    sum_w     = {1'b0, acc_q} + {1'b0, addend};
    b_rest    = b_q >> (shift_amt + 3'd2);
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    ovf_acc_d   = ovf_acc_q;
    product_d   = product_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d       = A;
          b_d       = B;
          acc_d     = '0;
          ovf_acc_d = 1'b0;
          k_d       = 2'd0;
          state_d   = RUN;
        end
      end
      RUN: begin
        acc_d     = sum_w[W-1:0];
        ovf_acc_d = ovf_acc_q | sum_w[W];
        // Stop once the remaining multiplier slices are all zero.
        if (k_q == 2'd2 || b_rest == 6'd0) begin
          state_d     = DONE;
          product_d   = sum_w[W-1:0];
          ovf_d       = ovf_acc_q | sum_w[W];
          out_valid_d = 1'b1;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    in_ready   = (state_q == IDLE);
    lay_A      = '0;
    lay_B_low  = 1'b0;
    lay_B_high = 1'b0;
    lay_cin    = 1'b0;
    if (state_q == RUN) begin
      lay_A      = a_q;
      lay_B_low  = b_q[shift_amt];
      lay_B_high = b_q[shift_amt + 3'd1];
    end
    out_valid = out_valid_q;
    product   = product_q;
    ovf       = ovf_q;
  end

endmodule
